store_pack_buffer: RTL
======================

Name: store_pack_buffer

Overview:
- Store-side counterpart to the load/immediate extension path: narrows a 32-bit register operand to byte, half or word.
- Places the narrowed data on the correct little-endian byte lanes, generates byte strobes and word-aligns the address.
- Queues packed stores in a small FIFO and drains them to data memory over a valid/ready handshake.
- Sits between the MEM-stage store issue and the data memory port.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- st_valid  input  1  store request valid.
- st_ready  output  1  buffer can accept a request.
- st_addr  input  32  byte address of the store.
- st_data  input  32  register value; only the low bytes are used for byte/half stores.
- st_size  input  2  store size: 00 byte, 01 half, 10 word, 11 illegal.
- mem_valid  output  1  head entry valid toward memory.
- mem_ready  input  1  memory accepts the head entry.
- mem_addr  output  32  word-aligned address, {st_addr[31:2],2'b00}.
- mem_wdata  output  32  lane-placed write data.
- mem_wstrb  output  4  byte enables; bit i enables bits [8i+7:8i].
- align_err  output  1  one-cycle pulse for a misaligned or illegal request.
- sb_empty  output  1  FIFO holds no entries; used as a store fence.
- sb_count  output  PTR_W+1  current occupancy.

Behaviour:
- Reset values:
  - count 0; read and write pointers 0.
  - mem_valid 0, align_err 0, sb_empty 1, sb_count 0.
  - mem_addr, mem_wdata and mem_wstrb all 0.
  - rst wins over any concurrent handshake; in-flight entries are discarded.
- Handshakes:
  - Input accept = st_valid & st_ready. st_ready = (count != DEPTH), depends only on registered state.
  - A full FIFO does not accept in the same cycle a dequeue occurs (no full bypass).
  - Output transfer = mem_valid & mem_ready. mem_valid = (count != 0).
  - While mem_valid is 1 and mem_ready is 0, mem_addr, mem_wdata and mem_wstrb hold stable.
- Packing is combinational at the input and registered into the FIFO entry (addr, wdata, wstrb). Let o = st_addr[1:0]:
  - byte (00): wdata = {4{st_data[7:0]}}; wstrb = 4'b0001 << o; never misaligned.
  - half (01): wdata = {2{st_data[15:0]}}; wstrb = o[1] ? 1100 : 0011; misaligned if o[0] = 1.
  - word (10): wdata = st_data; wstrb = 1111; misaligned if o != 00.
  - size 11: illegal.
- Error handling:
  - A misaligned or illegal request is consumed (st_ready behaves normally) but not enqueued.
  - align_err = 1 in the cycle after the accept, for exactly one cycle.
  - An error request arriving while full is not accepted and raises no error until it is accepted.
- Latency:
  - An accepted request appears on the mem_* outputs no earlier than the next cycle.
  - Empty FIFO: the entry is visible the cycle after accept; there is no combinational input-to-output bypass.
- Pointers and count:
  - Pointers wrap modulo DEPTH.
  - Simultaneous enqueue and dequeue on a non-full, non-empty FIFO leaves count unchanged and advances both pointers.
  - Enqueue on empty plus mem_ready in the same cycle does not dequeue, since mem_valid was 0.
- Empty outputs: when count = 0, mem_addr, mem_wdata and mem_wstrb are driven to 0.
- sb_empty = (count == 0); sb_count = count. Both are registered-state derived.

Test Plan:
- Byte store: addr 0x1003, data 0xAABBCCDD, size 00, mem_ready=1 → next cycle mem_addr 0x1000, wdata 0xDDDDDDDD, wstrb 1000; then sb_empty returns to 1.
- Half store: addr 0x2002, data 0x12345678, size 01 → wdata 0x56785678, wstrb 1100. Repeat with addr 0x2001 → align_err pulses one cycle, mem_valid stays 0, sb_count stays 0.
- Fill: hold mem_ready=0 and push 5 word stores 0x10, 0x14, 0x18, 0x1C, 0x20 → first four accepted, sb_count 4, st_ready 0. Raise mem_ready → drains in order 0x10…0x1C, then 0x20 is accepted.
- Simultaneous: count 2, enqueue and dequeue each cycle for 8 cycles → count stays 2, pointers wrap, data order preserved.
- Illegal size 11 at addr 0x0, plus word at addr 0x6 → two align_err pulses, no enqueue.
- Reset mid-operation: 3 entries queued, assert rst for one cycle → the next cycle shows mem_valid 0, sb_count 0, sb_empty 1, and outputs all zero.

Source files
------------

// File: rtl/store_pack_buffer.sv
// Store-side pack buffer: narrows a register operand to byte/half/word, places it on
// little-endian byte lanes with strobes, and queues it in a FIFO drained by valid/ready.
module store_pack_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [1:0]       st_size,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  output logic             align_err,
  output logic             sb_empty,
  output logic [PTR_W:0]   sb_count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]      addr_q  [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [3:0]       strb_q  [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             err_q;

  logic [31:0] pk_data;
  logic [3:0]  pk_strb;
  logic        pk_err;
  logic [1:0]  off;
  logic        accept, enq, deq;

  assign off = st_addr[1:0];

  always_comb begin
    pk_data = '0;
    pk_strb = '0;
    pk_err  = 1'b0;
    case (st_size)
      2'b00: begin
        pk_data = {4{st_data[7:0]}};
        pk_strb = 4'b0001 << off;
      end
      2'b01: begin
        pk_data = {2{st_data[15:0]}};
        pk_strb = off[1] ? 4'b1100 : 4'b0011;
        pk_err  = off[0];
      end
      2'b10: begin
        pk_data = st_data;
        pk_strb = 4'b1111;
        pk_err  = (off != 2'b00);
      end
      default: pk_err = 1'b1;
    endcase
  end

  // st_ready comes only from count, so a full buffer never takes a request even
  // when the head is draining in the same cycle.
  assign st_ready  = (count != FULL);
  assign mem_valid = (count != '0);
  assign accept    = st_valid & st_ready;
  assign enq       = accept & ~pk_err;
  assign deq       = mem_valid & mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept & pk_err;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr]  <= {st_addr[31:2], 2'b00};
      wdata_q[wr_ptr] <= pk_data;
      strb_q[wr_ptr]  <= pk_strb;
    end
  end

  assign mem_addr  = mem_valid ? addr_q[rd_ptr]  : '0;
  assign mem_wdata = mem_valid ? wdata_q[rd_ptr] : '0;
  assign mem_wstrb = mem_valid ? strb_q[rd_ptr]  : '0;
  assign align_err = err_q;
  assign sb_empty  = (count == '0);
  assign sb_count  = count;

endmodule
